// File: rtl/alu_32b_pipe.sv
// alu_32b_pipe: two-stage pipelined ALU with valid/ready handshakes.
//
// Stage 1 registers the conditioned operands (x, y, cin) so that NOT, SUB
// and NEG reduce to plain logic or a single adder in stage 2. Stage 2
// registers the result and the Z/N/C/V flags.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    upstream handshake for a, b, op
//   a, b                   operands (WIDTH bits)
//   op                     000 NOT A, 001 AND, 010 OR, 011 XOR,
//                          100 ADD, 101 SUB (A-B), 110 PASS B, 111 NEG (-A)
//   out_valid / out_ready  downstream handshake for z and flags
//   z                      result
//   flag_z, flag_n         result is zero, result sign bit
//   flag_c, flag_v         carry out / signed overflow (ADD, SUB, NEG only)
module alu_32b_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_PASS = 3'b110,
        OP_NEG  = 3'b111
    } op_e;

    // Stage 1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic             s1_cin;
    op_e              s1_op;

    // Stage 2 state
    logic             s2_valid;

    // Pipeline advance conditions
    logic s2_adv;
    logic s1_adv;

    // Stage 1 operand conditioning
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic             cin_d;

    // Stage 2 evaluation
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_d;
    logic             c_d;
    logic             v_d;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_comb begin
        x_d   = a;
        y_d   = b;
        cin_d = 1'b0;
        unique case (op_e'(op))
            OP_NOT: x_d = ~a;
            OP_SUB: begin
                y_d   = ~b;
                cin_d = 1'b1;
            end
            OP_NEG: begin
                // -A computed as ~A + 0 + 1
                x_d   = ~a;
                y_d   = '0;
                cin_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_cin   <= 1'b0;
            s1_op    <= OP_NOT;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x   <= x_d;
                s1_y   <= y_d;
                s1_cin <= cin_d;
                s1_op  <= op_e'(op);
            end
        end
    end

    assign sum = {1'b0, s1_x} + {1'b0, s1_y} + {{WIDTH{1'b0}}, s1_cin};

    always_comb begin
        res_d = sum[WIDTH-1:0];
        c_d   = 1'b0;
        v_d   = 1'b0;
        unique case (s1_op)
            OP_NOT:  res_d = s1_x;
            OP_AND:  res_d = s1_x & s1_y;
            OP_OR:   res_d = s1_x | s1_y;
            OP_XOR:  res_d = s1_x ^ s1_y;
            OP_PASS: res_d = s1_y;
            OP_ADD, OP_SUB, OP_NEG: begin
                c_d = sum[WIDTH];
                // Overflow: addends share a sign that the sum does not
                v_d = (s1_x[WIDTH-1] == s1_y[WIDTH-1]) &&
                      (sum[WIDTH-1] != s1_x[WIDTH-1]);
            end
            default: ;
        endcase
    end

    // Result and flags load only when a valid op moves in; otherwise they
    // hold their last value while s2_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            z        <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                z      <= res_d;
                flag_z <= (res_d == '0);
                flag_n <= res_d[WIDTH-1];
                flag_c <= c_d;
                flag_v <= v_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_32b_pipe.sv
// tb_alu_32b_pipe: directed self-checking bench for alu_32b_pipe.
// Inputs change on the falling edge; outputs are sampled shortly after.
module tb_alu_32b_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        flag_v;

    int errors = 0;
    int checks = 0;

    alu_32b_pipe #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z        (z),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_c   (flag_c),
        .flag_v   (flag_v)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags packed as {Z, N, C, V}
    function automatic logic [3:0] flags();
        return {flag_z, flag_n, flag_c, flag_v};
    endfunction

    // One isolated op: accepted at the first rising edge, visible two edges later.
    task automatic run_one(input string tag, input logic [2:0] o, input logic [31:0] aa,
                           input logic [31:0] bb, input logic [31:0] ez, input logic [3:0] ef);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = aa; b = bb; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_early"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_z"}, z, ez);
        check({tag, "_flags"}, {28'b0, flags()}, {28'b0, ef});
    endtask

    // Expected results for ops 0..7 on a=0000f0f0, b=00ff00ff
    logic [31:0] st_z [8];
    logic [3:0]  st_f [8];

    // Stream of ops 0..7; out_ready low for cycles [stall_lo, stall_hi].
    task automatic run_stream(input string tag, input int stall_lo, input int stall_hi);
        int          sent = 0;
        int          got = 0;
        int          first_cyc = -1;
        int          last_cyc = -1;
        int          stall_cnt = 0;
        logic [31:0] prev_z = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            in_valid  = (sent < 8);
            op        = 3'(sent);
            a         = 32'h0000f0f0;
            b         = 32'h00ff00ff;
            #1;
            if (out_valid && !out_ready) begin
                stall_cnt++;
                if (stall_cnt >= 2) begin
                    check({tag, "_stall_in_ready"}, {31'b0, in_ready}, 32'd0);
                    check({tag, "_stall_z_hold"}, z, prev_z);
                end
            end else begin
                stall_cnt = 0;
            end
            prev_z = z;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (got < 8) begin
                    check({tag, "_z"}, z, st_z[got]);
                    check({tag, "_flags"}, {28'b0, flags()}, {28'b0, st_f[got]});
                end else begin
                    check({tag, "_extra_output"}, 32'(got), 32'd7);
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, 32'(got), 32'd8);
        if (stall_lo > 30) begin
            check({tag, "_first_cycle"}, 32'(first_cyc), 32'd2);
            check({tag, "_span"}, 32'(last_cyc - first_cyc), 32'd7);
        end
    endtask

    initial begin
        st_z[0] = 32'hffff0f0f; st_f[0] = 4'b0100;
        st_z[1] = 32'h000000f0; st_f[1] = 4'b0000;
        st_z[2] = 32'h00fff0ff; st_f[2] = 4'b0000;
        st_z[3] = 32'h00fff00f; st_f[3] = 4'b0000;
        st_z[4] = 32'h00fff1ef; st_f[4] = 4'b0000;
        st_z[5] = 32'hff01eff1; st_f[5] = 4'b0100;
        st_z[6] = 32'h00ff00ff; st_f[6] = 4'b0000;
        st_z[7] = 32'hffff0f10; st_f[7] = 4'b0100;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_z", z, 32'd0);
        check("rst_flags", {28'b0, flags()}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("not1",    3'b000, 32'h00000001, 32'h0,        32'hfffffffe, 4'b0100);
        run_one("sub55",   3'b101, 32'd5,        32'd5,        32'h00000000, 4'b1010);
        run_one("sub01",   3'b101, 32'd0,        32'd1,        32'hffffffff, 4'b0100);
        run_one("add_ovf", 3'b100, 32'h7fffffff, 32'd1,        32'h80000000, 4'b0101);
        run_one("add_cy",  3'b100, 32'hffffffff, 32'd1,        32'h00000000, 4'b1010);
        run_one("neg_min", 3'b111, 32'h80000000, 32'h0,        32'h80000000, 4'b0101);
        run_one("neg_0",   3'b111, 32'h00000000, 32'h0,        32'h00000000, 4'b1010);
        run_one("not_ff",  3'b000, 32'hffffffff, 32'h0,        32'h00000000, 4'b1000);
        run_one("and",     3'b001, 32'hf0f0a5a5, 32'h0ff0ffff, 32'h00f0a5a5, 4'b0000);
        run_one("pass",    3'b110, 32'h12345678, 32'h9abcdef0, 32'h9abcdef0, 4'b0100);

        // Idle output keeps last result with valid low
        @(negedge clk);
        #1;
        check("idle_valid", {31'b0, out_valid}, 32'd0);
        check("idle_z_hold", z, 32'h9abcdef0);

        run_stream("stream", 99, 99);
        run_stream("stall", 4, 7);

        // Two ops in flight, then asynchronous reset mid-cycle
        @(negedge clk);
        in_valid = 1'b1; op = 3'b100; a = 32'd1; b = 32'd2; out_ready = 1'b0;
        @(negedge clk);
        a = 32'd3; b = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_valid", {31'b0, out_valid}, 32'd1);
        check("inflight_z", z, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_z", z, 32'd0);
        check("arst_flags", {28'b0, flags()}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
        end
        run_one("post_rst_add", 3'b100, 32'd10, 32'd20, 32'd30, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
